// File: rtl/dmem_arbiter.sv
// Two-port arbiter and fixed-length sequencer for the shared data SRAM bank.
// Each access runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE. The ack and
// the captured read data are registered and go only to the port that was granted.
module dmem_arbiter #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [3:0]        core_be,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [3:0]        dbg_be,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dout,
    output logic              sram_dout_en,
    input  logic [31:0]       sram_din,
    output logic              busy
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              gnt_dbg, gnt_dbg_nxt;     // grantee of the current access: 1 = dbg
    logic              last_dbg, last_dbg_nxt;   // last grant went to dbg
    logic              acc_we, acc_we_nxt;
    logic [3:0]        acc_be, acc_be_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [31:0]       dout_nxt;
    logic              core_cap, dbg_cap;
    logic              pick_dbg;

    // State and latched-request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt_dbg  <= 1'b0;
            last_dbg <= 1'b1;
            acc_we   <= 1'b0;
            acc_be   <= 4'hF;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            gnt_dbg  <= gnt_dbg_nxt;
            last_dbg <= last_dbg_nxt;
            acc_we   <= acc_we_nxt;
            acc_be   <= acc_be_nxt;
        end
    end

    // Arbitration, cycle counting and next-state decode
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        gnt_dbg_nxt  = gnt_dbg;
        last_dbg_nxt = last_dbg;
        acc_we_nxt   = acc_we;
        acc_be_nxt   = acc_be;
        addr_nxt     = sram_addr;
        dout_nxt     = sram_dout;
        core_cap     = 1'b0;
        dbg_cap      = 1'b0;
        pick_dbg     = dbg_req && (!core_req || !last_dbg);
        case (state)
            IDLE: begin
                if (core_req || dbg_req) begin
                    gnt_dbg_nxt  = pick_dbg;
                    last_dbg_nxt = pick_dbg;
                    acc_we_nxt   = pick_dbg ? dbg_we    : core_we;
                    acc_be_nxt   = pick_dbg ? dbg_be    : core_be;
                    addr_nxt     = pick_dbg ? dbg_addr  : core_addr;
                    dout_nxt     = pick_dbg ? dbg_wdata : core_wdata;
                    cnt_nxt      = CNT_W'(WAIT_CYCLES);
                    state_nxt    = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = DONE;
                    core_cap  = !acc_we && !gnt_dbg;
                    dbg_cap   = !acc_we && gnt_dbg;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered SRAM controls, acks and read data, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_ce      <= 1'b1;
            sram_oe      <= 1'b1;
            sram_we      <= 1'b1;
            sram_be      <= 4'hF;
            sram_addr    <= '0;
            sram_dout    <= '0;
            sram_dout_en <= 1'b0;
            core_ack     <= 1'b0;
            dbg_ack      <= 1'b0;
            core_rdata   <= '0;
            dbg_rdata    <= '0;
            busy         <= 1'b0;
        end else begin
            sram_ce      <= (state_nxt != ACCESS);
            sram_oe      <= !((state_nxt == ACCESS) && !acc_we_nxt);
            sram_we      <= !((state_nxt == ACCESS) && acc_we_nxt);
            sram_be      <= (state_nxt == ACCESS) ? acc_be_nxt : 4'hF;
            sram_addr    <= addr_nxt;
            sram_dout    <= dout_nxt;
            sram_dout_en <= (state_nxt == ACCESS) && acc_we_nxt;
            core_ack     <= (state_nxt == DONE) && !gnt_dbg_nxt;
            dbg_ack      <= (state_nxt == DONE) && gnt_dbg_nxt;
            busy         <= (state_nxt != IDLE);
            if (core_cap) core_rdata <= sram_din;
            if (dbg_cap)  dbg_rdata  <= sram_din;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural SRAM array plus three
// instances (WAIT_CYCLES = 1, 0 and 3) checked cycle by cycle.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [14:0] core_addr, dbg_addr;
    logic [3:0]  core_be, dbg_be;
    logic [31:0] core_wdata, dbg_wdata;
    logic [31:0] core_rdata, dbg_rdata;
    logic        core_ack, dbg_ack;
    logic        sram_ce, sram_oe, sram_we, sram_dout_en, busy;
    logic [3:0]  sram_be;
    logic [14:0] sram_addr;
    logic [31:0] sram_dout, sram_din;

    // secondary instances: dbg reads only
    logic        r0_req, r3_req;
    logic [14:0] q_addr;
    logic [31:0] w0_crd, w0_drd, w3_crd, w3_drd, w0_dout, w3_dout, w0_din, w3_din;
    logic        w0_cack, w0_dack, w3_cack, w3_dack, w0_busy, w3_busy;
    logic        w0_ce, w0_oe, w0_we, w0_den, w3_ce, w3_oe, w3_we, w3_den;
    logic [3:0]  w0_be, w3_be;
    logic [14:0] w0_addr, w3_addr;

    logic [31:0] mem [0:32767];

    int checks = 0;
    int passes = 0;

    dmem_arbiter #(.ADDR_W(15), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_be(core_be),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_be(dbg_be),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we), .sram_be(sram_be),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
        .sram_din(sram_din), .busy(busy));

    dmem_arbiter #(.ADDR_W(15), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .core_req(1'b0), .core_we(1'b0), .core_addr(15'h0), .core_be(4'hF),
        .core_wdata(32'h0), .core_rdata(w0_crd), .core_ack(w0_cack),
        .dbg_req(r0_req), .dbg_we(1'b0), .dbg_addr(q_addr), .dbg_be(4'h0),
        .dbg_wdata(32'h0), .dbg_rdata(w0_drd), .dbg_ack(w0_dack),
        .sram_ce(w0_ce), .sram_oe(w0_oe), .sram_we(w0_we), .sram_be(w0_be),
        .sram_addr(w0_addr), .sram_dout(w0_dout), .sram_dout_en(w0_den),
        .sram_din(w0_din), .busy(w0_busy));

    dmem_arbiter #(.ADDR_W(15), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst),
        .core_req(1'b0), .core_we(1'b0), .core_addr(15'h0), .core_be(4'hF),
        .core_wdata(32'h0), .core_rdata(w3_crd), .core_ack(w3_cack),
        .dbg_req(r3_req), .dbg_we(1'b0), .dbg_addr(q_addr), .dbg_be(4'h0),
        .dbg_wdata(32'h0), .dbg_rdata(w3_drd), .dbg_ack(w3_dack),
        .sram_ce(w3_ce), .sram_oe(w3_oe), .sram_we(w3_we), .sram_be(w3_be),
        .sram_addr(w3_addr), .sram_dout(w3_dout), .sram_dout_en(w3_den),
        .sram_din(w3_din), .busy(w3_busy));

    assign sram_din = mem[sram_addr];
    assign w0_din   = mem[w0_addr];
    assign w3_din   = mem[w3_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM write model for the main instance, byte lanes active low
    always @(negedge clk) begin
        if (!sram_ce && !sram_we) begin
            for (int i = 0; i < 4; i++)
                if (!sram_be[i]) mem[sram_addr][i*8 +: 8] = sram_dout[i*8 +: 8];
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(); step();
        checks++; if ({sram_ce, sram_oe, sram_we} !== 3'b111) $display("FAIL rst_ctl got %b exp 111", {sram_ce, sram_oe, sram_we}); else passes++;
        checks++; if (sram_be !== 4'hF) $display("FAIL rst_be got %h exp f", sram_be); else passes++;
        checks++; if ({sram_addr, sram_dout} !== 47'h0) $display("FAIL rst_addr_dout got %h/%h exp 0/0", sram_addr, sram_dout); else passes++;
        checks++; if ({sram_dout_en, core_ack, dbg_ack, busy} !== 4'b0000) $display("FAIL rst_flags got %b exp 0000", {sram_dout_en, core_ack, dbg_ack, busy}); else passes++;
        checks++; if ({core_rdata, dbg_rdata} !== 64'h0) $display("FAIL rst_rdata got %h/%h exp 0/0", core_rdata, dbg_rdata); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_core_read;
        core_req = 1'b1; core_we = 1'b0; core_addr = 15'h0010; core_be = 4'h0;
        step();
        checks++; if ({sram_ce, sram_oe, sram_we, sram_dout_en, busy} !== 5'b00101) $display("FAIL rd_c1 got %b exp 00101", {sram_ce, sram_oe, sram_we, sram_dout_en, busy}); else passes++;
        checks++; if (sram_addr !== 15'h0010) $display("FAIL rd_addr got %h exp 0010", sram_addr); else passes++;
        step();
        checks++; if ({sram_ce, sram_oe, core_ack} !== 3'b000) $display("FAIL rd_c2 got %b exp 000", {sram_ce, sram_oe, core_ack}); else passes++;
        step();
        checks++; if ({core_ack, dbg_ack, sram_ce, sram_oe} !== 4'b1011) $display("FAIL rd_c3 got %b exp 1011", {core_ack, dbg_ack, sram_ce, sram_oe}); else passes++;
        checks++; if (core_rdata !== 32'hDEADBEEF) $display("FAIL rd_data got %h exp deadbeef", core_rdata); else passes++;
        core_req = 1'b0;
        step();
        checks++; if ({core_ack, busy} !== 2'b00) $display("FAIL rd_c4 got %b exp 00", {core_ack, busy}); else passes++;
    endtask

    task automatic test_core_write;
        core_req = 1'b1; core_we = 1'b1; core_addr = 15'h0004; core_be = 4'b1101; core_wdata = 32'h0000AB00;
        step();
        checks++; if ({sram_ce, sram_oe, sram_we, sram_dout_en} !== 4'b0101) $display("FAIL wr_c1 got %b exp 0101", {sram_ce, sram_oe, sram_we, sram_dout_en}); else passes++;
        checks++; if (sram_be !== 4'b1101) $display("FAIL wr_be got %b exp 1101", sram_be); else passes++;
        step();
        checks++; if ({sram_we, sram_dout_en} !== 2'b01) $display("FAIL wr_c2 got %b exp 01", {sram_we, sram_dout_en}); else passes++;
        step();
        checks++; if ({core_ack, sram_we, sram_dout_en, sram_be} !== 7'b1101111) $display("FAIL wr_c3 got %b exp 1101111", {core_ack, sram_we, sram_dout_en, sram_be}); else passes++;
        checks++; if ({sram_addr, sram_dout} !== {15'h0004, 32'h0000AB00}) $display("FAIL wr_hold got %h/%h exp 0004/0000ab00", sram_addr, sram_dout); else passes++;
        checks++; if (core_rdata !== 32'hDEADBEEF) $display("FAIL wr_rdata got %h exp deadbeef", core_rdata); else passes++;
        core_req = 1'b0;
        step();
        // readback of the merged word
        core_req = 1'b1; core_we = 1'b0; core_be = 4'h0;
        step(); step(); step();
        checks++; if ({core_ack, core_rdata} !== {1'b1, 32'h1122AB44}) $display("FAIL wr_readback got %b/%h exp 1/1122ab44", core_ack, core_rdata); else passes++;
        core_req = 1'b0;
        step();
    endtask

    task automatic test_no_lanes;
        core_req = 1'b1; core_we = 1'b1; core_addr = 15'h0010; core_be = 4'hF; core_wdata = 32'h0;
        step();
        checks++; if ({sram_ce, sram_we, sram_be} !== 6'b001111) $display("FAIL nl_c1 got %b exp 001111", {sram_ce, sram_we, sram_be}); else passes++;
        step(); step();
        checks++; if (core_ack !== 1'b1) $display("FAIL nl_ack got %b exp 1", core_ack); else passes++;
        checks++; if (mem[15'h0010] !== 32'hDEADBEEF) $display("FAIL nl_mem got %h exp deadbeef", mem[15'h0010]); else passes++;
        core_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back;
        logic [12:0] cv, dv;
        cv = '0; dv = '0;
        rst = 1'b1; step(); rst = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 15'h0010; core_be = 4'h0;
        dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 15'h0004; dbg_be  = 4'h0;
        for (int c = 1; c <= 12; c++) begin
            step();
            cv[c] = core_ack;
            dv[c] = dbg_ack;
            if (c == 7) begin
                checks++; if (dbg_rdata !== 32'h1122AB44) $display("FAIL b2b_dbg_data got %h exp 1122ab44", dbg_rdata); else passes++;
            end
        end
        core_req = 1'b0; dbg_req = 1'b0;
        checks++; if (cv !== 13'b0_1000_0000_1000) $display("FAIL b2b_core_acks got %b exp 0100000001000", cv); else passes++;
        checks++; if (dv !== 13'b0_0000_1000_0000) $display("FAIL b2b_dbg_acks got %b exp 0000010000000", dv); else passes++;
        checks++; if (core_rdata !== 32'hDEADBEEF) $display("FAIL b2b_core_data got %h exp deadbeef", core_rdata); else passes++;
        step(); step();
        checks++; if (busy !== 1'b0) $display("FAIL b2b_idle got %b exp 0", busy); else passes++;
    endtask

    task automatic test_wait_cycles;
        logic [7:0] a0, b0, a3, b3;
        a0 = '0; b0 = '0; a3 = '0; b3 = '0;
        q_addr = 15'h0010; r0_req = 1'b1; r3_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            a0[c] = w0_dack; b0[c] = w0_busy;
            a3[c] = w3_dack; b3[c] = w3_busy;
            if (w0_dack) r0_req = 1'b0;
            if (w3_dack) r3_req = 1'b0;
        end
        checks++; if (a0 !== 8'b0000_0100) $display("FAIL w0_ack got %b exp 00000100", a0); else passes++;
        checks++; if (b0 !== 8'b0000_0110) $display("FAIL w0_busy got %b exp 00000110", b0); else passes++;
        checks++; if (a3 !== 8'b0010_0000) $display("FAIL w3_ack got %b exp 00100000", a3); else passes++;
        checks++; if (b3 !== 8'b0011_1110) $display("FAIL w3_busy got %b exp 00111110", b3); else passes++;
        checks++; if ({w0_drd, w3_drd} !== {32'hDEADBEEF, 32'hDEADBEEF}) $display("FAIL wc_data got %h/%h exp deadbeef/deadbeef", w0_drd, w3_drd); else passes++;
        r0_req = 1'b0; r3_req = 1'b0;
    endtask

    task automatic test_reset_mid_access;
        mem[15'h0008] = 32'h0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 15'h0008; core_be = 4'h0; core_wdata = 32'h55AA55AA;
        step();
        checks++; if ({sram_ce, sram_we} !== 2'b00) $display("FAIL rm_c1 got %b exp 00", {sram_ce, sram_we}); else passes++;
        #1 rst = 1'b1;
        #1;
        checks++; if ({sram_ce, sram_we, sram_dout_en, core_ack, busy} !== 5'b11000) $display("FAIL rm_async got %b exp 11000", {sram_ce, sram_we, sram_dout_en, core_ack, busy}); else passes++;
        step();
        checks++; if (core_ack !== 1'b0) $display("FAIL rm_noack got %b exp 0", core_ack); else passes++;
        step();
        rst = 1'b0;
        step();
        checks++; if ({sram_we, sram_addr} !== {1'b0, 15'h0008}) $display("FAIL rm_rerun got %b/%h exp 0/0008", sram_we, sram_addr); else passes++;
        step(); step();
        checks++; if (core_ack !== 1'b1) $display("FAIL rm_ack got %b exp 1", core_ack); else passes++;
        checks++; if (mem[15'h0008] !== 32'h55AA55AA) $display("FAIL rm_mem got %h exp 55aa55aa", mem[15'h0008]); else passes++;
        core_req = 1'b0;
        step();
    endtask

    task automatic test_input_hold;
        mem[15'h0020] = 32'h0; mem[15'h0030] = 32'h0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 15'h0010; dbg_be = 4'h0;
        step(); step(); step();
        checks++; if ({dbg_ack, dbg_rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL ih_dbg got %b/%h exp 1/deadbeef", dbg_ack, dbg_rdata); else passes++;
        dbg_req = 1'b0;
        step();
        core_req = 1'b1; core_we = 1'b1; core_addr = 15'h0020; core_be = 4'h0; core_wdata = 32'h01020304;
        step();
        core_addr = 15'h0030; core_wdata = 32'hFFFFFFFF; dbg_addr = 15'h0004;
        step();
        checks++; if ({sram_addr, sram_dout} !== {15'h0020, 32'h01020304}) $display("FAIL ih_c2 got %h/%h exp 0020/01020304", sram_addr, sram_dout); else passes++;
        step();
        checks++; if ({core_ack, sram_addr, sram_dout} !== {1'b1, 15'h0020, 32'h01020304}) $display("FAIL ih_c3 got %b/%h/%h exp 1/0020/01020304", core_ack, sram_addr, sram_dout); else passes++;
        checks++; if (dbg_rdata !== 32'hDEADBEEF) $display("FAIL ih_dbg_rdata got %h exp deadbeef", dbg_rdata); else passes++;
        checks++; if ({mem[15'h0020], mem[15'h0030]} !== {32'h01020304, 32'h0}) $display("FAIL ih_mem got %h/%h exp 01020304/00000000", mem[15'h0020], mem[15'h0030]); else passes++;
        core_req = 1'b0;
        step();
    endtask

    // Time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
        mem[15'h0010] = 32'hDEADBEEF;
        mem[15'h0004] = 32'h11223344;
        rst = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_be = 4'hF; core_wdata = '0;
        dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_be  = 4'hF; dbg_wdata  = '0;
        r0_req = 1'b0; r3_req = 1'b0; q_addr = '0;
        test_reset();
        test_core_read();
        test_core_write();
        test_no_lanes();
        test_back_to_back();
        test_wait_cycles();
        test_reset_mid_access();
        test_input_hold();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Sequencing controller and two-port arbiter for the shared data SRAM bank (four byte-wide async SRAMs, active-low controls, 15-bit word address). Arbitrates between the core load/store path and a debug/loader port. Runs each access as a fixed-length multi-cycle SRAM cycle, registers address and data, and returns a one-cycle acknowledge with registered read data. Sits between the backend memory stage and the SRAM chips; the core stalls on its request until it receives core_ack.

Parameters:
ADDR_W, 15, word address width (byte address bits [16:2])
WAIT_CYCLES, 1, extra SRAM-active cycles beyond the first (0..7)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
core_req  in  1  core access request, active high, held until core_ack
core_we  in  1  1 = write, 0 = read
core_addr  in  ADDR_W  word address
core_be  in  4  byte enables, ACTIVE LOW, bit i = byte lane i
core_wdata  in  32  write data, already lane-replicated
core_rdata  out  32  registered read data
core_ack  out  1  one-cycle completion pulse
dbg_req, dbg_we, dbg_addr, dbg_be, dbg_wdata, dbg_rdata, dbg_ack  same widths, directions and meanings as the core_* ports, for the debug/loader port
sram_ce  out  1  chip enable, ACTIVE LOW
sram_oe  out  1  output enable, ACTIVE LOW
sram_we  out  1  write enable, ACTIVE LOW
sram_be  out  4  per-lane chip select, ACTIVE LOW
sram_addr  out  ADDR_W  registered word address
sram_dout  out  32  registered write data
sram_dout_en  out  1  drive enable for the data-bus transceiver, active high
sram_din  in  32  data returned by the SRAM
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, immediate): state IDLE; sram_ce, sram_oe and sram_we = 1; sram_be = 4'hF; sram_addr = 0; sram_dout = 0; sram_dout_en = 0; both acks = 0; both rdata = 0; cnt = 0; last_grant = dbg, so the core wins the first tie.
- States: IDLE, ACCESS, DONE.
- IDLE: if any request is asserted, grant at the clock edge:
  - Exactly one requester: that requester is granted.
  - Both requesters: the port that was not last_grant is granted (round-robin).
  - On grant, register the grantee, we, addr, be and wdata into sram_addr, sram_be and sram_dout; set cnt = WAIT_CYCLES; update last_grant; go to ACCESS.
- ACCESS:
  - sram_ce = 0 and sram_be = registered be.
  - Read: sram_oe = 0, sram_we = 1, sram_dout_en = 0.
  - Write: sram_we = 0, sram_oe = 1, sram_dout_en = 1.
  - If cnt != 0, decrement cnt. If cnt == 0, go to DONE at the next edge; for a read, capture sram_din into the grantee's rdata at that same edge.
- DONE (recovery cycle):
  - All SRAM controls deasserted; sram_be = 4'hF; sram_dout_en = 0.
  - sram_addr and sram_dout held, giving address and data hold after the WE rising edge.
  - Grantee's ack = 1 for exactly this cycle. Go to IDLE.
- Latency: request first seen in cycle 0 → ACCESS occupies cycles 1..WAIT_CYCLES+1 → ack in cycle WAIT_CYCLES+2. The earliest next grant is the edge after the IDLE cycle that follows DONE.
- Requesters drop req in the cycle after ack. A req still high in IDLE is a new request.
- Request inputs are sampled only at grant. Changes to them during ACCESS or DONE have no effect.
- rdata of a port changes only on completion of that port's read. Writes never alter either rdata. The other port's rdata is untouched.
- A write with be = 4'hF still runs the full cycle with no lane selected, and is acked.
- The non-granted request stays pending. It is never lost or dropped; it is served in the next arbitration.
- Reset during ACCESS: controls deassert immediately, no ack is issued, and the pending requests are re-arbitrated after reset release (core first).
- The SRAM read is combinational; read data is valid by the end of the final ACCESS cycle.

Test Plan:
1. Core read, WAIT_CYCLES=1, SRAM word 0x0010 = 0xDEADBEEF → sram_ce/sram_oe low in cycles 1-2, core_ack in cycle 3, core_rdata = 0xDEADBEEF, dbg_ack stays 0.
2. Core write addr 0x0004, be = 4'b1101, wdata 0x0000AB00, word preloaded 0x11223344 → sram_we low for 2 cycles, sram_be = 1101, sram_dout_en high only in ACCESS; a readback returns 0x1122AB44.
3. Both requests asserted in the same cycle right after reset → core ack in cycle 3, dbg ack in cycle 7. With both held continuously, grants alternate core, dbg, core.
4. WAIT_CYCLES = 0, then 3, single dbg read → ack in cycle 2, then in cycle 5. busy is high from cycle 1 through the ack cycle.
5. rst asserted mid-ACCESS of a core write → sram_we and sram_ce go high in the same cycle, no ack; after release with core_req still high, the access reruns and acks.
6. Core changes core_addr and core_wdata during ACCESS of its own write → sram_addr and sram_dout hold the values granted; dbg_rdata stays unchanged.
